// File: rtl/pipeline_control_ldst_arbiter.sv
// Two-requester arbiter for the core's single load/store port.
// An in-order ID FIFO routes each LDST response back to the requester that issued it.
module pipeline_control_ldst_arbiter #(
  parameter int unsigned P_OUTSTANDING = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iA_USE,
  input  logic        iA_REQ,
  input  logic [1:0]  iA_ORDER,
  input  logic        iA_RW,
  input  logic [31:0] iA_ADDR,
  input  logic [31:0] iA_DATA,
  input  logic        iB_USE,
  input  logic        iB_REQ,
  input  logic [1:0]  iB_ORDER,
  input  logic        iB_RW,
  input  logic [31:0] iB_ADDR,
  input  logic [31:0] iB_DATA,
  output logic        oA_BUSY,
  output logic        oA_VALID,
  output logic [31:0] oA_DATA,
  output logic        oB_BUSY,
  output logic        oB_VALID,
  output logic [31:0] oB_DATA,
  output logic        oLDST_USE,
  output logic        oLDST_REQ,
  output logic [1:0]  oLDST_ORDER,
  output logic        oLDST_RW,
  output logic [31:0] oLDST_ADDR,
  output logic [31:0] oLDST_DATA,
  input  logic        iLDST_BUSY,
  input  logic        iLDST_REQ,
  input  logic [31:0] iLDST_DATA,
  output logic        oPROTO_ERR
);

  localparam int unsigned PTR_W = (P_OUTSTANDING > 1) ? $clog2(P_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic        ID_A  = 1'b0;
  localparam logic        ID_B  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_last_grant;
  logic                     w_last_grant_next;
  logic [P_OUTSTANDING-1:0] r_id_fifo;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic w_own_a;
  logic w_own_b;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_issue;
  logic w_pop;
  logic w_head_id;

  assign w_own_a      = (r_state == ST_OWN_A);
  assign w_own_b      = (r_state == ST_OWN_B);
  assign w_fifo_full  = (r_count == CNT_W'(P_OUTSTANDING));
  assign w_fifo_empty = (r_count == '0);
  assign w_head_id    = r_id_fifo[r_rd_ptr];

  // Issue needs a live owner; a pop in the same cycle does not free a slot for a full FIFO.
  assign w_issue = !iRESET_SYNC && !iLDST_BUSY && !w_fifo_full &&
                   ((w_own_a && iA_USE && iA_REQ) || (w_own_b && iB_USE && iB_REQ));
  assign w_pop   = !iRESET_SYNC && iLDST_REQ && !w_fifo_empty;

  // State register, grant history and response-ID FIFO.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ID_B;
      r_id_fifo    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      if (w_issue) begin
        r_id_fifo[r_wr_ptr] <= w_own_b ? ID_B : ID_A;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state and port outputs; every output is forced to its reset value while reset is high.
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    oLDST_USE         = 1'b0;
    oLDST_REQ         = w_issue;
    oLDST_ORDER       = 2'b00;
    oLDST_RW          = 1'b0;
    oLDST_ADDR        = 32'h0;
    oLDST_DATA        = 32'h0;
    oA_BUSY           = 1'b1;
    oB_BUSY           = 1'b1;
    oA_VALID          = w_pop && (w_head_id == ID_A);
    oB_VALID          = w_pop && (w_head_id == ID_B);
    oA_DATA           = iLDST_DATA;
    oB_DATA           = iLDST_DATA;
    oPROTO_ERR        = !iRESET_SYNC && iLDST_REQ && w_fifo_empty;

    case (r_state)
      ST_IDLE: begin
        if (iA_USE && (!iB_USE || (r_last_grant == ID_B))) begin
          w_state_next      = ST_OWN_A;
          w_last_grant_next = ID_A;
        end else if (iB_USE) begin
          w_state_next      = ST_OWN_B;
          w_last_grant_next = ID_B;
        end
      end
      ST_OWN_A: begin
        if (!iA_USE) begin
          if (iB_USE) begin
            w_state_next      = ST_OWN_B;
            w_last_grant_next = ID_B;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_OWN_B: begin
        if (!iB_USE) begin
          if (iA_USE) begin
            w_state_next      = ST_OWN_A;
            w_last_grant_next = ID_A;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (!iRESET_SYNC) begin
      oLDST_USE = (r_state != ST_IDLE) || !w_fifo_empty;
      oA_BUSY   = !w_own_a || iLDST_BUSY || w_fifo_full;
      oB_BUSY   = !w_own_b || iLDST_BUSY || w_fifo_full;
      if (w_own_a) begin
        oLDST_ORDER = iA_ORDER;
        oLDST_RW    = iA_RW;
        oLDST_ADDR  = iA_ADDR;
        oLDST_DATA  = iA_DATA;
      end else if (w_own_b) begin
        oLDST_ORDER = iB_ORDER;
        oLDST_RW    = iB_RW;
        oLDST_ADDR  = iB_ADDR;
        oLDST_DATA  = iB_DATA;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control_ldst_arbiter.sv
// Scoreboard bench for pipeline_control_ldst_arbiter: issued IDs are queued, responses must route to the queued owner.
module tb_pipeline_control_ldst_arbiter;

  logic        iCLOCK;
  logic        iRESET_SYNC;
  logic        iA_USE, iA_REQ, iA_RW;
  logic [1:0]  iA_ORDER;
  logic [31:0] iA_ADDR, iA_DATA;
  logic        iB_USE, iB_REQ, iB_RW;
  logic [1:0]  iB_ORDER;
  logic [31:0] iB_ADDR, iB_DATA;
  logic        oA_BUSY, oA_VALID, oB_BUSY, oB_VALID;
  logic [31:0] oA_DATA, oB_DATA;
  logic        oLDST_USE, oLDST_REQ, oLDST_RW;
  logic [1:0]  oLDST_ORDER;
  logic [31:0] oLDST_ADDR, oLDST_DATA;
  logic        iLDST_BUSY, iLDST_REQ;
  logic [31:0] iLDST_DATA;
  logic        oPROTO_ERR;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  bit          exp_q[$];

  pipeline_control_ldst_arbiter #(.P_OUTSTANDING(4)) u_dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
    .iA_USE(iA_USE), .iA_REQ(iA_REQ), .iA_ORDER(iA_ORDER), .iA_RW(iA_RW),
    .iA_ADDR(iA_ADDR), .iA_DATA(iA_DATA),
    .iB_USE(iB_USE), .iB_REQ(iB_REQ), .iB_ORDER(iB_ORDER), .iB_RW(iB_RW),
    .iB_ADDR(iB_ADDR), .iB_DATA(iB_DATA),
    .oA_BUSY(oA_BUSY), .oA_VALID(oA_VALID), .oA_DATA(oA_DATA),
    .oB_BUSY(oB_BUSY), .oB_VALID(oB_VALID), .oB_DATA(oB_DATA),
    .oLDST_USE(oLDST_USE), .oLDST_REQ(oLDST_REQ), .oLDST_ORDER(oLDST_ORDER),
    .oLDST_RW(oLDST_RW), .oLDST_ADDR(oLDST_ADDR), .oLDST_DATA(oLDST_DATA),
    .iLDST_BUSY(iLDST_BUSY), .iLDST_REQ(iLDST_REQ), .iLDST_DATA(iLDST_DATA),
    .oPROTO_ERR(oPROTO_ERR)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_use"},   32'(oLDST_USE), 32'd0);
    chk({tag, "_req"},   32'(oLDST_REQ), 32'd0);
    chk({tag, "_addr"},  oLDST_ADDR, 32'd0);
    chk({tag, "_data"},  oLDST_DATA, 32'd0);
    chk({tag, "_order"}, 32'(oLDST_ORDER), 32'd0);
    chk({tag, "_rw"},    32'(oLDST_RW), 32'd0);
    chk({tag, "_busy"},  32'({oA_BUSY, oB_BUSY}), 32'd3);
    chk({tag, "_valid"}, 32'({oA_VALID, oB_VALID}), 32'd0);
    chk({tag, "_perr"},  32'(oPROTO_ERR), 32'd0);
  endtask

  // One cycle: drive requests and/or a response, score at the falling edge.
  task automatic step(input logic req_a, input logic req_b, input logic rw,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic rsp, input logic [31:0] rdata, input logic exp_issue);
    bit id;
    iA_REQ = req_a; iB_REQ = req_b; iA_RW = rw; iB_RW = rw;
    iA_ADDR = addr; iB_ADDR = addr; iA_DATA = wdata; iB_DATA = wdata;
    iLDST_REQ = rsp; iLDST_DATA = rdata;
    @(negedge iCLOCK);
    if (rsp) begin
      if (exp_q.size() != 0) begin
        id = exp_q.pop_front();
        chk("rsp_a_valid", 32'(oA_VALID), 32'(id == 1'b0));
        chk("rsp_b_valid", 32'(oB_VALID), 32'(id == 1'b1));
        chk("rsp_data", id ? oB_DATA : oA_DATA, rdata);
        chk("rsp_perr", 32'(oPROTO_ERR), 32'd0);
      end else begin
        chk("orphan_perr", 32'(oPROTO_ERR), 32'd1);
        chk("orphan_valid", 32'({oA_VALID, oB_VALID}), 32'd0);
      end
    end else begin
      chk("quiet_valid", 32'({oA_VALID, oB_VALID, oPROTO_ERR}), 32'd0);
    end
    chk("issue", 32'(oLDST_REQ), 32'(exp_issue));
    if (exp_issue) begin
      chk("issue_addr", oLDST_ADDR, addr);
      chk("issue_rw", 32'(oLDST_RW), 32'(rw));
      chk("issue_order", 32'(oLDST_ORDER), 32'd2);
      if (rw) chk("issue_wdata", oLDST_DATA, wdata);
      exp_q.push_back(req_b);
    end
    nxt();
    iA_REQ = 1'b0; iB_REQ = 1'b0; iLDST_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iRESET_SYNC = 1'b1;
    iA_USE = 0; iA_REQ = 0; iA_RW = 0; iA_ORDER = 2'b10; iA_ADDR = 0; iA_DATA = 0;
    iB_USE = 0; iB_REQ = 0; iB_RW = 0; iB_ORDER = 2'b10; iB_ADDR = 0; iB_DATA = 0;
    iLDST_BUSY = 0; iLDST_REQ = 0; iLDST_DATA = 0;
    @(negedge iCLOCK);
    chk_reset_outputs("por");
    nxt(); nxt();
    iRESET_SYNC = 1'b0;

    // Basic ownership and read response.
    iA_USE = 1'b1;
    #1 chk("grant_lat_busy", 32'(oA_BUSY), 32'd1);
    nxt();
    #1 chk("own_a_busy", 32'({oA_BUSY, oB_BUSY}), 32'b01);
    chk("own_a_use", 32'(oLDST_USE), 32'd1);
    step(1, 0, 0, 32'h100, 32'h0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0);
    iA_USE = 1'b0;
    nxt();
    #1 chk("idle_use", 32'(oLDST_USE), 32'd0);

    // Tie after reset goes to A, then round-robin.
    iRESET_SYNC = 1'b1; nxt(); iRESET_SYNC = 1'b0;
    iA_USE = 1'b1; iB_USE = 1'b1;
    nxt();
    #1 chk("tie1_owner", 32'({oA_BUSY, oB_BUSY}), 32'b01);
    iA_USE = 1'b0;
    nxt();
    #1 chk("handoff_owner", 32'({oA_BUSY, oB_BUSY}), 32'b10);
    iB_USE = 1'b0;
    nxt();
    #1 chk("release_idle", 32'({oA_BUSY, oB_BUSY}), 32'b11);
    iA_USE = 1'b1; iB_USE = 1'b1;
    nxt();
    #1 chk("tie2_owner", 32'({oA_BUSY, oB_BUSY}), 32'b01);
    iA_USE = 1'b0; iB_USE = 1'b0;
    nxt();

    // Handoff with accesses in flight.
    iA_USE = 1'b1;
    nxt();
    step(1, 0, 0, 32'h200, 32'h0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h204, 32'h0, 0, 32'h0, 1);
    iA_USE = 1'b0; iB_USE = 1'b1;
    nxt();
    step(0, 1, 1, 32'h300, 32'hCAFE0001, 0, 32'h0, 1);
    iB_USE = 1'b0;
    nxt();
    #1 chk("inflight_use", 32'(oLDST_USE), 32'd1);
    chk("noowner_addr", oLDST_ADDR, 32'd0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h11, 0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h22, 0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h33, 0);
    #1 chk("drained_use", 32'(oLDST_USE), 32'd0);

    // Full FIFO: push refused even when a pop happens in the same cycle.
    iA_USE = 1'b1;
    nxt();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h400 + 32'(4 * i), 32'h0, 0, 32'h0, 1);
    #1 chk("full_busy", 32'(oA_BUSY), 32'd1);
    step(1, 0, 0, 32'h500, 32'h0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h504, 32'h0, 1, 32'hA0, 0);
    #1 chk("after_pop_busy", 32'(oA_BUSY), 32'd0);
    step(1, 0, 0, 32'h508, 32'h0, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 32'h0, 1, 32'hB0 + 32'(i), 0);

    // Orphan response, LDST back-pressure, same-cycle issue and orphan response.
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h77, 0);
    iLDST_BUSY = 1'b1;
    #1 chk("ldst_busy_owner", 32'(oA_BUSY), 32'd1);
    step(1, 0, 0, 32'h600, 32'h0, 0, 32'h0, 0);
    iLDST_BUSY = 1'b0;
    step(1, 0, 0, 32'h700, 32'h0, 1, 32'h88, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h99, 0);

    // Reset with two accesses outstanding.
    step(1, 0, 0, 32'h800, 32'h0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h804, 32'h0, 0, 32'h0, 1);
    iRESET_SYNC = 1'b1; iA_REQ = 1'b1; iLDST_REQ = 1'b1;
    @(negedge iCLOCK);
    chk_reset_outputs("in_rst");
    nxt();
    iRESET_SYNC = 1'b0; iA_USE = 1'b0; iA_REQ = 1'b0; iLDST_REQ = 1'b0;
    #1 chk_reset_outputs("post_rst");
    exp_q.delete();
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h55, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipeline_control_ldst_arbiter.md
# pipeline_control_ldst_arbiter

Shares the core's single load/store port between two requesters: A (execution pipeline) and B (system sequencers such as the IDT reader). A requester gains ownership by asserting USE and keeps it while USE stays high. Issued accesses are tagged in an in-order ID FIFO so that each response (iLDST_REQ) returns to the requester that issued it, including after an ownership handoff. Sits in pipeline_control between the requesters and the LDST unit.

## Interface
- P_OUTSTANDING, 4: depth of the response-ID FIFO; maximum number of accesses in flight (power of two, ≥2).
- iCLOCK  in  1  clock, all logic on rising edge.
- iRESET_SYNC  in  1  reset, synchronous, active-high; the only reset.
- iA_USE / iB_USE  in  1  ownership request / hold.
- iA_REQ / iB_REQ  in  1  access request; honoured only from the current owner.
- iA_ORDER / iB_ORDER  in  2  00=byte 01=2-byte 10=word 11=none.
- iA_RW / iB_RW  in  1  0=read 1=write.
- iA_ADDR / iB_ADDR  in  32  address.
- iA_DATA / iB_DATA  in  32  write data.
- oA_BUSY / oB_BUSY  out  1  issue refused this cycle.
- oA_VALID / oB_VALID  out  1  response for this requester this cycle.
- oA_DATA / oB_DATA  out  32  response data (iLDST_DATA passthrough).
- oLDST_USE  out  1  owner present or FIFO non-empty.
- oLDST_REQ  out  1  access issue strobe.
- oLDST_ORDER  out  2  / oLDST_RW  out  1 / oLDST_ADDR  out  32 / oLDST_DATA  out  32  owner's fields muxed; zero when there is no owner.
- iLDST_BUSY  in  1  LDST cannot accept an access.
- iLDST_REQ  in  1  response strobe, one per issued access, in issue order.
- iLDST_DATA  in  32  response data.
- oPROTO_ERR  out  1  one-cycle pulse on a response with an empty FIFO.

## Operation
- States: IDLE, OWN_A, OWN_B (registered). Register last_grant (A/B).
- IDLE: only A_USE → OWN_A; only B_USE → OWN_B; both → the requester ≠ last_grant. last_grant updates on every grant.
- OWN_X: stays while iX_USE=1. On iX_USE=0: go to OWN_other if other USE=1 (last_grant ← other), else IDLE. No wait for outstanding responses.
- issue = owner's REQ && owner's USE && !iLDST_BUSY && !fifo_full. oLDST_REQ = issue (combinational). On issue, the owner ID is pushed.
- oX_BUSY = !(state==OWN_X) || iLDST_BUSY || fifo_full. oX_BUSY is valid whether or not REQ is asserted.
- Response: iLDST_REQ with FIFO non-empty pops the head. oHEAD_VALID=1 for the head ID in the same cycle. Data passes through; the other requester's VALID=0.
- Response with FIFO empty: dropped; oPROTO_ERR=1 for that cycle.
- Simultaneous push and pop: both occur and the count is unchanged. When full, push is blocked even if a pop occurs in the same cycle.
- Count width is log2(P_OUTSTANDING)+1. Pointers wrap modulo P_OUTSTANDING.

## Timing
- Reset values: state=IDLE, last_grant=B (A wins the first tie), FIFO empty.
- Output values during and after reset: oLDST_USE=0, oLDST_REQ=0, oLDST_* fields=0, oA/oB_BUSY=1, oA/oB_VALID=0, oPROTO_ERR=0.
- Grant latency: USE asserted in cycle n (IDLE) → owner in cycle n+1 → first issue possible in n+1.
- Release: USE low in cycle n → new state in n+1. REQ in cycle n is ignored.
- Response routing is zero-latency: VALID and DATA appear in the same cycle as iLDST_REQ.
- Issue and response for the same ID in the same cycle (empty FIFO): the push and pop are separate. The response in that cycle belongs to the old head, so it raises PROTO_ERR if the FIFO was empty before the push.
- Reset mid-operation: the FIFO is flushed and the state returns to IDLE. Responses that arrive later raise PROTO_ERR.

## Test plan
- Ownership: A_USE=1 at cycle 0, REQ read addr 0x100 at cycle 1 with BUSY=0 → oLDST_REQ=1, ADDR=0x100 at cycle 1. Response data 0xDEADBEEF → oA_VALID=1, oA_DATA=0xDEADBEEF, oB_VALID=0.
- Tie and round-robin: both USE rise together after reset → OWN_A. A drops USE → OWN_B next cycle. Both rise again from IDLE → OWN_A (last_grant=B).
- Handoff with in-flight accesses: A issues 2 reads, drops USE, B issues 1 write. Three responses arrive → VALID sequence A, A, B.
- Full FIFO with P_OUTSTANDING=4: 4 issues with no response → oA_BUSY=1 and the 5th REQ is not issued. One response → BUSY drops next cycle. Push is not granted in the full-cycle pop.
- Errors: iLDST_REQ with empty FIFO → oPROTO_ERR pulses 1 cycle, no VALID. iLDST_BUSY=1 → oLDST_REQ=0 and owner BUSY=1.
- Reset mid-operation: iRESET_SYNC with 2 outstanding → all outputs at reset values next cycle. A later response → PROTO_ERR.
